// File: rtl/key_pkg.sv
// Shared scan-code constants, key classes and entry states for the numeric entry path.
// Keypad codes are only decoded when KEY_DIGIT_KEYPAD_EN is defined.
package key_pkg;

    localparam logic [8:0] SC_0     = 9'h045;
    localparam logic [8:0] SC_1     = 9'h016;
    localparam logic [8:0] SC_2     = 9'h01E;
    localparam logic [8:0] SC_3     = 9'h026;
    localparam logic [8:0] SC_4     = 9'h025;
    localparam logic [8:0] SC_5     = 9'h02E;
    localparam logic [8:0] SC_6     = 9'h036;
    localparam logic [8:0] SC_7     = 9'h03D;
    localparam logic [8:0] SC_8     = 9'h03E;
    localparam logic [8:0] SC_9     = 9'h046;
    localparam logic [8:0] SC_BKSP  = 9'h066;
    localparam logic [8:0] SC_ENTER = 9'h05A;
    localparam logic [8:0] SC_ESC   = 9'h076;

    localparam logic [8:0] KP_0     = 9'h070;
    localparam logic [8:0] KP_1     = 9'h069;
    localparam logic [8:0] KP_2     = 9'h072;
    localparam logic [8:0] KP_3     = 9'h07A;
    localparam logic [8:0] KP_4     = 9'h06B;
    localparam logic [8:0] KP_5     = 9'h073;
    localparam logic [8:0] KP_6     = 9'h074;
    localparam logic [8:0] KP_7     = 9'h06C;
    localparam logic [8:0] KP_8     = 9'h075;
    localparam logic [8:0] KP_9     = 9'h07D;
    localparam logic [8:0] KP_ENTER = 9'h15A;

    typedef enum logic [2:0] {
        KC_NONE  = 3'd0,
        KC_DIGIT = 3'd1,
        KC_BKSP  = 3'd2,
        KC_ENTER = 3'd3,
        KC_ESC   = 3'd4
    } key_class_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/key_classify.sv
// Combinational scan-code classifier: last_change -> {key class, digit value}.
// Numeric keypad codes decode as digits/Enter only when KEY_DIGIT_KEYPAD_EN is defined.
module key_classify
    import key_pkg::*;
(
    input  logic [8:0]  i_code,
    output key_class_e  o_class,
    output logic [3:0]  o_digit
);

    // Map each recognised code to its class; anything else is KC_NONE.
    always_comb begin
        o_class = KC_NONE;
        o_digit = 4'd0;
        case (i_code)
            SC_0:     begin o_class = KC_DIGIT; o_digit = 4'd0; end
            SC_1:     begin o_class = KC_DIGIT; o_digit = 4'd1; end
            SC_2:     begin o_class = KC_DIGIT; o_digit = 4'd2; end
            SC_3:     begin o_class = KC_DIGIT; o_digit = 4'd3; end
            SC_4:     begin o_class = KC_DIGIT; o_digit = 4'd4; end
            SC_5:     begin o_class = KC_DIGIT; o_digit = 4'd5; end
            SC_6:     begin o_class = KC_DIGIT; o_digit = 4'd6; end
            SC_7:     begin o_class = KC_DIGIT; o_digit = 4'd7; end
            SC_8:     begin o_class = KC_DIGIT; o_digit = 4'd8; end
            SC_9:     begin o_class = KC_DIGIT; o_digit = 4'd9; end
            SC_BKSP:  o_class = KC_BKSP;
            SC_ENTER: o_class = KC_ENTER;
            SC_ESC:   o_class = KC_ESC;
`ifdef KEY_DIGIT_KEYPAD_EN
            KP_0:     begin o_class = KC_DIGIT; o_digit = 4'd0; end
            KP_1:     begin o_class = KC_DIGIT; o_digit = 4'd1; end
            KP_2:     begin o_class = KC_DIGIT; o_digit = 4'd2; end
            KP_3:     begin o_class = KC_DIGIT; o_digit = 4'd3; end
            KP_4:     begin o_class = KC_DIGIT; o_digit = 4'd4; end
            KP_5:     begin o_class = KC_DIGIT; o_digit = 4'd5; end
            KP_6:     begin o_class = KC_DIGIT; o_digit = 4'd6; end
            KP_7:     begin o_class = KC_DIGIT; o_digit = 4'd7; end
            KP_8:     begin o_class = KC_DIGIT; o_digit = 4'd8; end
            KP_9:     begin o_class = KC_DIGIT; o_digit = 4'd9; end
            KP_ENTER: o_class = KC_ENTER;
`endif
            default:  begin o_class = KC_NONE; o_digit = 4'd0; end
        endcase
    end

endmodule

// File: rtl/key_digit_entry.sv
// Multi-digit BCD entry buffer with Backspace/Esc/Enter and a valid/ready commit port.
// Build with KEY_DIGIT_KEYPAD_EN defined to also accept numeric keypad codes.
module key_digit_entry
    import key_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter bit CLR_ON_COMMIT = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8:0]            last_change,
    input  logic                  key_event,
    output logic [4*DIGITS-1:0]   entry_bcd,
    output logic [3:0]            entry_len,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow
);

    localparam int         W       = 4 * DIGITS;
    localparam logic [3:0] LEN_MAX = 4'(DIGITS);

    key_class_e     w_class;
    logic [3:0]     w_digit;
    logic           w_xfer;

    state_e         r_state, w_state_nxt;
    logic [W-1:0]   r_entry, w_entry_nxt;
    logic [3:0]     r_len,   w_len_nxt;
    logic [W-1:0]   r_out,   w_out_nxt;
    logic           r_valid, w_valid_nxt;
    logic           r_ovf,   w_ovf_nxt;

    key_classify u_classify (
        .i_code  (last_change),
        .o_class (w_class),
        .o_digit (w_digit)
    );

    assign w_xfer = r_valid & out_ready;

    // Next-state: edit the entry on a key event, then let a handshake retire out_valid.
    always_comb begin
        w_entry_nxt = r_entry;
        w_len_nxt   = r_len;
        w_out_nxt   = r_out;
        w_valid_nxt = r_valid;
        w_ovf_nxt   = r_ovf;
        w_state_nxt = r_state;
        if (key_event) begin
            case (w_class)
                KC_DIGIT: begin
                    if (r_len < LEN_MAX) begin
                        w_entry_nxt = (r_entry << 3'd4) | W'(w_digit);
                        w_len_nxt   = r_len + 4'd1;
                    end else begin
                        w_ovf_nxt   = 1'b1;
                    end
                end
                KC_BKSP: begin
                    if (r_len != 4'd0) begin
                        w_entry_nxt = r_entry >> 3'd4;
                        w_len_nxt   = r_len - 4'd1;
                    end else begin
                        w_entry_nxt = r_entry;
                    end
                end
                KC_ESC: begin
                    w_entry_nxt = '0;
                    w_len_nxt   = 4'd0;
                    w_ovf_nxt   = 1'b0;
                end
                KC_ENTER: begin
                    // Only ENTRY commits: EMPTY has nothing to send, HOLD must not overwrite.
                    if (r_state == ENTRY) begin
                        w_out_nxt   = r_entry;
                        w_valid_nxt = 1'b1;
                        if (CLR_ON_COMMIT) begin
                            w_entry_nxt = '0;
                            w_len_nxt   = 4'd0;
                        end else begin
                            w_entry_nxt = r_entry;
                        end
                    end else begin
                        w_valid_nxt = r_valid;
                    end
                end
                default: begin
                    w_entry_nxt = r_entry;
                end
            endcase
        end else begin
            w_entry_nxt = r_entry;
        end

        if (w_xfer) begin
            w_valid_nxt = 1'b0;
        end else begin
            w_out_nxt = w_out_nxt;
        end

        if (w_valid_nxt) begin
            w_state_nxt = HOLD;
        end else if (w_len_nxt == 4'd0) begin
            w_state_nxt = EMPTY;
        end else begin
            w_state_nxt = ENTRY;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
            r_entry <= '0;
            r_len   <= 4'd0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_entry <= w_entry_nxt;
            r_len   <= w_len_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign entry_bcd = r_entry;
    assign entry_len = r_len;
    assign out_bcd   = r_out;
    assign out_valid = r_valid;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_key_digit_entry.sv
// Self-checking bench for key_digit_entry: two instances (clear / retain on commit)
// driven in lockstep, checked by directed scenarios and a randomized decimal-number model.
module tb_key_digit_entry;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        key_event = 1'b0;
    logic        out_ready = 1'b0;
    logic [8:0]  last_change = 9'h000;

    logic [15:0] e0, o0, e1, o1;
    logic [3:0]  l0, l1;
    logic        v0, v1, f0, f1;

    int vectors = 0;
    int errors  = 0;

    // Reference model: entry kept as a decimal integer plus a digit count.
    int m_val [2];
    int m_len [2];
    int m_out [2];
    bit m_valid [2];
    bit m_ovf [2];

    int unsigned main_codes [10] = '{32'h045, 32'h016, 32'h01E, 32'h026, 32'h025,
                                     32'h02E, 32'h036, 32'h03D, 32'h03E, 32'h046};
    int unsigned kp_codes   [10] = '{32'h070, 32'h069, 32'h072, 32'h07A, 32'h06B,
                                     32'h073, 32'h074, 32'h06C, 32'h075, 32'h07D};

    key_digit_entry #(.DIGITS(4), .CLR_ON_COMMIT(1'b1)) u0 (
        .clk(clk), .reset(reset), .last_change(last_change), .key_event(key_event),
        .entry_bcd(e0), .entry_len(l0), .out_bcd(o0), .out_valid(v0),
        .out_ready(out_ready), .overflow(f0)
    );

    key_digit_entry #(.DIGITS(4), .CLR_ON_COMMIT(1'b0)) u1 (
        .clk(clk), .reset(reset), .last_change(last_change), .key_event(key_event),
        .entry_bcd(e1), .entry_len(l1), .out_bcd(o1), .out_valid(v1),
        .out_ready(out_ready), .overflow(f1)
    );

    always #5 clk = ~clk;

    // 0 none, 1 digit, 2 backspace, 3 enter, 4 escape
    function automatic int classify(input logic [8:0] c, output int d);
        d = 0;
        for (int i = 0; i < 10; i++)
            if (c == 9'(main_codes[i])) begin d = i; return 1; end
`ifdef KEY_DIGIT_KEYPAD_EN
        for (int i = 0; i < 10; i++)
            if (c == 9'(kp_codes[i])) begin d = i; return 1; end
        if (c == 9'h15A) return 3;
`endif
        if (c == 9'h066) return 2;
        if (c == 9'h05A) return 3;
        if (c == 9'h076) return 4;
        return 0;
    endfunction

    function automatic logic [15:0] to_bcd(input int val, input int len);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < len; i++) begin
            r[4*i +: 4] = 4'(val % 10);
            val = val / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_val[k] = 0; m_len[k] = 0; m_out[k] = 0; m_valid[k] = 1'b0; m_ovf[k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit ev, input logic [8:0] code, input bit rdy);
        int d;
        int cls;
        bit xfer;
        for (int k = 0; k < 2; k++) begin
            xfer = m_valid[k] && rdy;
            if (ev) begin
                cls = classify(code, d);
                case (cls)
                    1: if (m_len[k] < 4) begin
                           m_val[k] = m_val[k] * 10 + d; m_len[k]++;
                       end else m_ovf[k] = 1'b1;
                    2: if (m_len[k] > 0) begin
                           m_val[k] = m_val[k] / 10; m_len[k]--;
                       end
                    3: if (!m_valid[k] && m_len[k] > 0) begin
                           m_out[k] = m_val[k]; m_valid[k] = 1'b1;
                           if (k == 0) begin m_val[k] = 0; m_len[k] = 0; end
                       end
                    4: begin m_val[k] = 0; m_len[k] = 0; m_ovf[k] = 1'b0; end
                    default: ;
                endcase
            end
            if (xfer) m_valid[k] = 1'b0;
        end
    endtask

    task automatic apply(input bit ev, input logic [8:0] code, input bit rdy);
        @(negedge clk);
        key_event   = ev;
        last_change = code;
        out_ready   = rdy;
        @(posedge clk);
        model_step(ev, code, rdy);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        key_event = 1'b0;
        out_ready = 1'b0;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        key_event = 1'b0;
        model_reset();
        #1;
        vectors++; if (e0 !== 16'h0000) begin errors++; $display("FAIL reset_entry got=%h exp=0000", e0); end
        vectors++; if (l0 !== 4'd0) begin errors++; $display("FAIL reset_len got=%0d exp=0", l0); end
        vectors++; if (o0 !== 16'h0000) begin errors++; $display("FAIL reset_out got=%h exp=0000", o0); end
        vectors++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", v0); end
        vectors++; if (f0 !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", f0); end
        vectors++; if (v1 !== 1'b0) begin errors++; $display("FAIL reset_valid1 got=%b exp=0", v1); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_digits();
        apply(1'b1, 9'h016, 1'b0);
        apply(1'b1, 9'h01E, 1'b0);
        apply(1'b1, 9'h026, 1'b0);
        vectors++; if (e0 !== 16'h0123) begin errors++; $display("FAIL digits_entry got=%h exp=0123", e0); end
        vectors++; if (l0 !== 4'd3) begin errors++; $display("FAIL digits_len got=%0d exp=3", l0); end
        vectors++; if (v0 !== 1'b0) begin errors++; $display("FAIL digits_valid got=%b exp=0", v0); end
        vectors++; if (e1 !== 16'h0123) begin errors++; $display("FAIL digits_entry1 got=%h exp=0123", e1); end
    endtask

    task automatic test_backspace();
        apply(1'b1, 9'h066, 1'b0);
        apply(1'b1, 9'h046, 1'b0);
        vectors++; if (e0 !== 16'h0129) begin errors++; $display("FAIL bksp_entry got=%h exp=0129", e0); end
        vectors++; if (l0 !== 4'd3) begin errors++; $display("FAIL bksp_len got=%0d exp=3", l0); end
        for (int i = 0; i < 3; i++) apply(1'b1, 9'h066, 1'b0);
        vectors++; if (e0 !== 16'h0000) begin errors++; $display("FAIL bksp_empty_entry got=%h exp=0000", e0); end
        vectors++; if (l0 !== 4'd0) begin errors++; $display("FAIL bksp_empty_len got=%0d exp=0", l0); end
        apply(1'b1, 9'h05A, 1'b0);
        vectors++; if (v0 !== 1'b0) begin errors++; $display("FAIL enter_on_empty got=%b exp=0", v0); end
    endtask

    task automatic test_overflow();
        apply(1'b1, 9'h02E, 1'b0);
        apply(1'b1, 9'h036, 1'b0);
        apply(1'b1, 9'h03D, 1'b0);
        apply(1'b1, 9'h03E, 1'b0);
        vectors++; if (f0 !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", f0); end
        apply(1'b1, 9'h046, 1'b0);
        vectors++; if (e0 !== 16'h5678) begin errors++; $display("FAIL ovf_entry got=%h exp=5678", e0); end
        vectors++; if (l0 !== 4'd4) begin errors++; $display("FAIL ovf_len got=%0d exp=4", l0); end
        vectors++; if (f0 !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", f0); end
        apply(1'b1, 9'h076, 1'b0);
        vectors++; if (e0 !== 16'h0000) begin errors++; $display("FAIL esc_entry got=%h exp=0000", e0); end
        vectors++; if (f0 !== 1'b0) begin errors++; $display("FAIL esc_ovf got=%b exp=0", f0); end
        vectors++; if (l0 !== 4'd0) begin errors++; $display("FAIL esc_len got=%0d exp=0", l0); end
    endtask

    task automatic test_commit_hold();
        apply(1'b1, 9'h025, 1'b0);
        apply(1'b1, 9'h01E, 1'b0);
        apply(1'b1, 9'h05A, 1'b0);
        vectors++; if (o0 !== 16'h0042) begin errors++; $display("FAIL commit_out got=%h exp=0042", o0); end
        vectors++; if (v0 !== 1'b1) begin errors++; $display("FAIL commit_valid got=%b exp=1", v0); end
        vectors++; if (e0 !== 16'h0000) begin errors++; $display("FAIL commit_clear got=%h exp=0000", e0); end
        vectors++; if (e1 !== 16'h0042) begin errors++; $display("FAIL commit_keep1 got=%h exp=0042", e1); end
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 9'h000, 1'b0);
            vectors++; if (v0 !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, v0); end
            vectors++; if (o0 !== 16'h0042) begin errors++; $display("FAIL hold_out[%0d] got=%h exp=0042", i, o0); end
        end
        apply(1'b1, 9'h026, 1'b0);
        apply(1'b1, 9'h05A, 1'b0);
        vectors++; if (o0 !== 16'h0042) begin errors++; $display("FAIL second_enter_out got=%h exp=0042", o0); end
        vectors++; if (e0 !== 16'h0003) begin errors++; $display("FAIL hold_edit got=%h exp=0003", e0); end
        vectors++; if (o1 !== 16'h0042) begin errors++; $display("FAIL second_enter_out1 got=%h exp=0042", o1); end
        vectors++; if (e1 !== 16'h0423) begin errors++; $display("FAIL hold_edit1 got=%h exp=0423", e1); end
        apply(1'b1, 9'h05A, 1'b1);
        vectors++; if (v0 !== 1'b0) begin errors++; $display("FAIL xfer_enter_valid got=%b exp=0", v0); end
        vectors++; if (o0 !== 16'h0042) begin errors++; $display("FAIL xfer_out got=%h exp=0042", o0); end
        vectors++; if (v1 !== 1'b0) begin errors++; $display("FAIL xfer_enter_valid1 got=%b exp=0", v1); end
        apply(1'b0, 9'h000, 1'b0);
        vectors++; if (v0 !== 1'b0) begin errors++; $display("FAIL after_xfer_valid got=%b exp=0", v0); end
        apply(1'b1, 9'h076, 1'b0);
    endtask

    task automatic test_no_clear();
        apply(1'b1, 9'h03D, 1'b1);
        apply(1'b1, 9'h05A, 1'b1);
        vectors++; if (v1 !== 1'b1) begin errors++; $display("FAIL noclr_valid got=%b exp=1", v1); end
        vectors++; if (o1 !== 16'h0007) begin errors++; $display("FAIL noclr_out got=%h exp=0007", o1); end
        vectors++; if (e1 !== 16'h0007) begin errors++; $display("FAIL noclr_entry got=%h exp=0007", e1); end
        vectors++; if (e0 !== 16'h0000) begin errors++; $display("FAIL clr_entry got=%h exp=0000", e0); end
        apply(1'b0, 9'h000, 1'b1);
        vectors++; if (v1 !== 1'b0) begin errors++; $display("FAIL noclr_pulse got=%b exp=0", v1); end
        vectors++; if (v0 !== 1'b0) begin errors++; $display("FAIL clr_pulse got=%b exp=0", v0); end
        vectors++; if (e1 !== 16'h0007) begin errors++; $display("FAIL noclr_retained got=%h exp=0007", e1); end
        vectors++; if (l1 !== 4'd1) begin errors++; $display("FAIL noclr_len got=%0d exp=1", l1); end
    endtask

    task automatic test_reset_mid_hold();
        apply(1'b1, 9'h02E, 1'b0);
        apply(1'b1, 9'h05A, 1'b0);
        vectors++; if (v0 !== 1'b1) begin errors++; $display("FAIL prereset_valid got=%b exp=1", v0); end
        @(negedge clk);
        key_event = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        vectors++; if (v0 !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", v0); end
        vectors++; if (o0 !== 16'h0000) begin errors++; $display("FAIL midrst_out got=%h exp=0000", o0); end
        vectors++; if (e1 !== 16'h0000) begin errors++; $display("FAIL midrst_entry1 got=%h exp=0000", e1); end
        vectors++; if (l1 !== 4'd0) begin errors++; $display("FAIL midrst_len1 got=%0d exp=0", l1); end
        vectors++; if (o1 !== 16'h0000) begin errors++; $display("FAIL midrst_out1 got=%h exp=0000", o1); end
        vectors++; if (f1 !== 1'b0) begin errors++; $display("FAIL midrst_ovf1 got=%b exp=0", f1); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_keypad();
        apply(1'b1, 9'h069, 1'b0);
        apply(1'b1, 9'h07D, 1'b0);
        apply(1'b1, 9'h15A, 1'b0);
`ifdef KEY_DIGIT_KEYPAD_EN
        vectors++; if (o0 !== 16'h0019) begin errors++; $display("FAIL keypad_out got=%h exp=0019", o0); end
        vectors++; if (v0 !== 1'b1) begin errors++; $display("FAIL keypad_valid got=%b exp=1", v0); end
`else
        vectors++; if (o0 !== 16'h0000) begin errors++; $display("FAIL keypad_out got=%h exp=0000", o0); end
        vectors++; if (v0 !== 1'b0) begin errors++; $display("FAIL keypad_valid got=%b exp=0", v0); end
        vectors++; if (l0 !== 4'd0) begin errors++; $display("FAIL keypad_len got=%0d exp=0", l0); end
`endif
    endtask

    task automatic test_random();
        bit          ev;
        bit          rdy;
        logic [8:0]  code;
        int          r;
        pulse_reset();
        for (int n = 0; n < 800; n++) begin
            ev = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 19);
            if (r < 10)       code = 9'(main_codes[r]);
            else if (r < 12)  code = 9'h066;
            else if (r < 15)  code = 9'h05A;
            else if (r == 15) code = 9'h076;
            else if (r == 16) code = 9'(kp_codes[$urandom_range(0, 9)]);
            else if (r == 17) code = 9'h15A;
            else              code = 9'($urandom_range(0, 511));
            rdy = ($urandom_range(0, 3) == 0);
            apply(ev, code, rdy);
            vectors++; if (e0 !== to_bcd(m_val[0], m_len[0])) begin errors++; $display("FAIL rnd_entry0 n=%0d got=%h exp=%h", n, e0, to_bcd(m_val[0], m_len[0])); end
            vectors++; if (l0 !== 4'(m_len[0])) begin errors++; $display("FAIL rnd_len0 n=%0d got=%0d exp=%0d", n, l0, m_len[0]); end
            vectors++; if (o0 !== to_bcd(m_out[0], 4)) begin errors++; $display("FAIL rnd_out0 n=%0d got=%h exp=%h", n, o0, to_bcd(m_out[0], 4)); end
            vectors++; if (v0 !== m_valid[0]) begin errors++; $display("FAIL rnd_valid0 n=%0d got=%b exp=%b", n, v0, m_valid[0]); end
            vectors++; if (f0 !== m_ovf[0]) begin errors++; $display("FAIL rnd_ovf0 n=%0d got=%b exp=%b", n, f0, m_ovf[0]); end
            vectors++; if (e1 !== to_bcd(m_val[1], m_len[1])) begin errors++; $display("FAIL rnd_entry1 n=%0d got=%h exp=%h", n, e1, to_bcd(m_val[1], m_len[1])); end
            vectors++; if (l1 !== 4'(m_len[1])) begin errors++; $display("FAIL rnd_len1 n=%0d got=%0d exp=%0d", n, l1, m_len[1]); end
            vectors++; if (o1 !== to_bcd(m_out[1], 4)) begin errors++; $display("FAIL rnd_out1 n=%0d got=%h exp=%h", n, o1, to_bcd(m_out[1], 4)); end
            vectors++; if (v1 !== m_valid[1]) begin errors++; $display("FAIL rnd_valid1 n=%0d got=%b exp=%b", n, v1, m_valid[1]); end
            vectors++; if (f1 !== m_ovf[1]) begin errors++; $display("FAIL rnd_ovf1 n=%0d got=%b exp=%b", n, f1, m_ovf[1]); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_digits();
        test_backspace();
        test_overflow();
        test_commit_hold();
        test_no_clear();
        test_reset_mid_hold();
        test_keypad();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
